stack_seq: RTL and testbench
============================

# stack_seq

Sequencer for the calculator's operand stack. The stack storage is an external `WIDTH*DEPTH`-bit serial shift register with these ports:
- `d`: serial data in.
- `en`: shift enable.
- `dir`: shift direction. 0 shifts left and inserts `d` at bit 0. 1 shifts right, inserts 0 at the top and drops bit 0.
- `rst`: synchronous clear.

`stack_seq` accepts word-level PUSH/POP/CLEAR commands and converts each into a burst of single-bit shifts. It tracks stack occupancy and returns popped words and error status to the ALU/control logic.

## Interface
- `WIDTH`, 4, bits per stack word.
- `DEPTH`, 4, number of words the external shift register holds. The register is `WIDTH*DEPTH` bits.
- `clk` input 1, the single clock. All logic is on the rising edge.
- `rst_n` input 1, reset. Synchronous and active-low.
- `cmd_valid` input 1, command present.
- `cmd_ready` output 1, block can accept a command. High only in IDLE.
- `cmd_op` input 2, command opcode: 00 PUSH, 01 POP, 10 CLEAR, 11 reserved.
- `cmd_data` input WIDTH, word to push. Ignored for other ops.
- `rsp_valid` output 1, one-cycle completion pulse. There is no backpressure.
- `rsp_data` output WIDTH, popped word. Valid with `rsp_valid` on a successful POP, otherwise 0.
- `rsp_err` output 1, error flag qualified by `rsp_valid`: overflow, underflow or reserved op.
- `count` output clog2(DEPTH+1), number of words currently on the stack.
- `sr_d` output 1, drives shift register `d`.
- `sr_en` output 1, drives shift register `en`.
- `sr_dir` output 1, drives shift register `dir`.
- `sr_rst` output 1, drives shift register `rst`.
- `sr_lsb` input 1, shift register `q[0]`.

## Operation
States: IDLE, PUSH, POP, CLR, DONE.
- **IDLE**
  - `cmd_ready`=1.
  - Handshake fires when `cmd_valid` && `cmd_ready` at a rising edge. `cmd_op` and `cmd_data` are latched at that edge.
  - Next state is decided at the handshake:
    - PUSH with `count`<DEPTH goes to PUSH.
    - POP with `count`>0 goes to POP.
    - CLEAR goes to CLR.
    - PUSH with `count`==DEPTH, POP with `count`==0, or op 11 go straight to DONE with the error latched.
- **PUSH**, WIDTH cycles, bit index i from WIDTH-1 down to 0:
  - `sr_en`=1, `sr_dir`=0, `sr_d`=latched data[i] (MSB first).
  - After the last bit: `count`+1, go to DONE.
- **POP**, WIDTH cycles:
  - `sr_en`=1, `sr_dir`=1.
  - Each cycle, capture `sr_lsb` (the pre-shift `q[0]`) into an accumulator: acc <= {`sr_lsb`, acc[WIDTH-1:1]}. The first bit captured is the word's LSB.
  - After the last bit: `count`-1, go to DONE.
- **CLR**, 1 cycle: `sr_rst`=1, `count`<=0, go to DONE.
- **DONE**, 1 cycle:
  - `rsp_valid`=1.
  - `rsp_err` as latched.
  - `rsp_data` = acc for a successful POP, else 0.
  - Next state IDLE.
- `sr_en`, `sr_d` and `sr_dir` are 0 in all states except those listed above.
- `count` never wraps. Guard checks happen only at the handshake, so it stays in 0..DEPTH.
- Error responses leave `count` and the shift register untouched.

## Timing
- Reset (`rst_n`=0 at an edge):
  - state<=IDLE, `count`<=0, acc<=0, error flag<=0.
  - `rsp_valid`, `rsp_err`, `rsp_data`, `sr_en`, `sr_d` and `sr_dir` are 0.
  - `cmd_ready`=0 while `rst_n` is low.
  - `sr_rst`=1 while `rst_n` is low, so the storage is cleared together with `count`.
- Reset asserted mid-PUSH or mid-POP aborts the burst immediately:
  - No `rsp_valid` is produced.
  - The storage is cleared by `sr_rst`.
  - `count` is 0 after reset.
- Handshake at edge E0:
  - PUSH/POP: `sr_en` high for cycles 1..WIDTH after E0. `rsp_valid` in cycle WIDTH+1. `cmd_ready` high again in cycle WIDTH+2. Throughput is one command per WIDTH+2 cycles.
  - CLEAR: `sr_rst` in cycle 1, `rsp_valid` in cycle 2.
  - Errors: `rsp_valid` in cycle 1.
- `count` updates at the same edge that enters DONE, so it is already updated while `rsp_valid` is high.
- `cmd_valid` held across a response is accepted only on the first IDLE cycle, never during DONE.

## Test plan
- **Push then LIFO pop.** After reset, PUSH 0xA then PUSH 0x3.
  - Required: `sr_d` sequence 1,0,1,0 then 0,0,1,1, with `sr_en` high 4 cycles each; `count`=2.
  - Then POP, POP: `rsp_data` 0x3 then 0xA, `rsp_err`=0, `count`=0.
- **Overflow.** PUSH 0x1,0x2,0x3,0x4 (`count`=4), then PUSH 0x5.
  - Required: `rsp_valid` one cycle after the handshake with `rsp_err`=1, no `sr_en` pulses, `count` stays 4.
  - A following POP returns 0x4.
- **Underflow and reserved op.**
  - POP on an empty stack: `rsp_err`=1, `rsp_data`=0, `count`=0.
  - Op 11: `rsp_err`=1, `count` unchanged.
- **Clear.** Push 3 words, then CLEAR.
  - Required: `sr_rst` high exactly 1 cycle, `rsp_valid` on the next cycle, `count`=0.
  - A following POP underflows.
- **Reset mid-burst.** Drop `rst_n` for 1 cycle at cycle 2 of a PUSH.
  - Required: no `rsp_valid`, `sr_rst`=1 during reset, `count`=0.
  - `cmd_ready`=1 on the first cycle after release; a subsequent PUSH 0x6 / POP returns 0x6.
- **Handshake timing.** Hold `cmd_valid` continuously with PUSH.
  - Required: accepts only in IDLE, one command every WIDTH+2=6 cycles; `cmd_ready` is 0 during the PUSH and DONE cycles.

Source files
------------

// File: rtl/stack_seq.sv
// Word-level PUSH/POP/CLEAR sequencer for a bit-serial operand stack.
// Each command becomes a burst of single-bit shifts on an external shift register.
module stack_seq #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [WIDTH-1:0]             cmd_data,
  output logic                         rsp_valid,
  output logic [WIDTH-1:0]             rsp_data,
  output logic                         rsp_err,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         sr_d,
  output logic                         sr_en,
  output logic                         sr_dir,
  output logic                         sr_rst,
  input  logic                         sr_lsb
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH,
    ST_POP,
    ST_CLR,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               err_q, err_d;
  logic               pop_ok_q, pop_ok_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      acc_q    <= '0;
      err_q    <= 1'b0;
      pop_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      acc_q    <= acc_d;
      err_q    <= err_d;
      pop_ok_q <= pop_ok_d;
    end
  end

  // Guards are evaluated only at the handshake, so count stays within 0..DEPTH.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    bit_d    = bit_q;
    data_d   = data_q;
    acc_d    = acc_q;
    err_d    = err_q;
    pop_ok_d = pop_ok_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          data_d   = cmd_data;
          bit_d    = BIT_LAST;
          acc_d    = '0;
          err_d    = 1'b0;
          pop_ok_d = 1'b0;
          case (cmd_op)
            OP_PUSH: begin
              if (count_q != DEPTH_C) begin
                state_d = ST_PUSH;
              end else begin
                err_d   = 1'b1;
                state_d = ST_DONE;
              end
            end
            OP_POP: begin
              if (count_q != '0) begin
                pop_ok_d = 1'b1;
                state_d  = ST_POP;
              end else begin
                err_d   = 1'b1;
                state_d = ST_DONE;
              end
            end
            OP_CLEAR: state_d = ST_CLR;
            default: begin
              err_d   = 1'b1;
              state_d = ST_DONE;
            end
          endcase
        end
      end
      ST_PUSH: begin
        if (bit_q == '0) begin
          count_d = count_q + CW'(1);
          state_d = ST_DONE;
        end else begin
          bit_d = bit_q - BW'(1);
        end
      end
      ST_POP: begin
        // Pre-shift q[0] arrives LSB first, so shift it in from the top.
        acc_d = {sr_lsb, acc_q[WIDTH-1:1]};
        if (bit_q == '0) begin
          count_d = count_q - CW'(1);
          state_d = ST_DONE;
        end else begin
          bit_d = bit_q - BW'(1);
        end
      end
      ST_CLR: begin
        count_d = '0;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced quiet during reset so an aborted burst never leaks a shift or response.
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
    sr_en     = 1'b0;
    sr_dir    = 1'b0;
    sr_d      = 1'b0;
    sr_rst    = !rst_n;
    if (rst_n) begin
      case (state_q)
        ST_IDLE: cmd_ready = 1'b1;
        ST_PUSH: begin
          sr_en = 1'b1;
          sr_d  = data_q[bit_q];
        end
        ST_POP: begin
          sr_en  = 1'b1;
          sr_dir = 1'b1;
        end
        ST_CLR: sr_rst = 1'b1;
        ST_DONE: begin
          rsp_valid = 1'b1;
          rsp_err   = err_q;
          rsp_data  = pop_ok_q ? acc_q : '0;
        end
        default: cmd_ready = 1'b0;
      endcase
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_stack_seq.sv
// Scoreboard bench for stack_seq: directed commands push expected responses,
// a monitor pops and compares on every rsp_valid; a model shift register closes the loop.
module tb_stack_seq;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int SRN   = WIDTH * DEPTH;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic       rsp_valid;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic [2:0] count;
  logic       sr_d, sr_en, sr_dir, sr_rst, sr_lsb;

  stack_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .count(count),
    .sr_d(sr_d), .sr_en(sr_en), .sr_dir(sr_dir), .sr_rst(sr_rst), .sr_lsb(sr_lsb)
  );

  always #5 clk = ~clk;

  // External serial storage
  logic [SRN-1:0] sr_q = '0;
  always @(posedge clk) begin
    if (sr_rst) sr_q <= '0;
    else if (sr_en) sr_q <= sr_dir ? {1'b0, sr_q[SRN-1:1]} : {sr_q[SRN-2:0], sr_d};
  end
  assign sr_lsb = sr_q[0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rsp    = 0;

  typedef struct {
    logic [3:0] data;
    logic       err;
    int         cnt;
    int         hs;
    int         lat;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: every response must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
      exp_t e;
      n_rsp++;
      $display("rsp %0d: data=0x%h err=%0d count=%0d cycle=%0d", n_rsp, rsp_data, rsp_err, count, cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_data", int'(rsp_data), int'(e.data));
        chk("rsp_err", int'(rsp_err), int'(e.err));
        chk("rsp_count", int'(count), e.cnt);
        chk("rsp_latency", cyc - e.hs, e.lat);
      end
    end
  end

  // Shift activity recorder
  logic [15:0] bits_v;
  int nbits, ndir1, nrst;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (sr_en) begin
        bits_v = {bits_v[14:0], sr_d};
        nbits++;
        if (sr_dir) ndir1++;
      end
      if (sr_rst) nrst++;
    end
  end

  task automatic clr_rec();
    bits_v = '0;
    nbits  = 0;
    ndir1  = 0;
    nrst   = 0;
  endtask

  task automatic wait_rsp();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(negedge clk);
      #2;
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [3:0] data,
                        input logic [3:0] ed, input logic ee, input int ec, input int lat);
    int   t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (cmd_ready !== 1'b1) begin
      chk("cmd_ready_timeout", 0, 1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    e.data = ed; e.err = ee; e.cnt = ec; e.hs = cyc; e.lat = lat;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 4'h0;
    wait_rsp();
  endtask

  localparam logic [1:0] PUSH = 2'b00, POP = 2'b01, CLEAR = 2'b10, RSVD = 2'b11;

  initial begin
    int   t, nr, hs_prev;
    exp_t e;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_data = 4'h0;
    clr_rec();

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", int'(cmd_ready), 0);
    chk("reset_sr_rst", int'(sr_rst), 1);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_sr_en", int'(sr_en), 0);
    chk("reset_count", int'(count), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_cmd_ready", int'(cmd_ready), 1);
    chk("post_reset_sr_rst", int'(sr_rst), 0);
    chk("post_reset_rsp_data", int'(rsp_data), 0);

    // Push then LIFO pop
    clr_rec();
    do_cmd(PUSH, 4'hA, 4'h0, 1'b0, 1, 5);
    chk("push_a_nbits", nbits, 4);
    chk("push_a_bits", int'(bits_v[3:0]), 'hA);
    chk("push_a_dir", ndir1, 0);
    clr_rec();
    do_cmd(PUSH, 4'h3, 4'h0, 1'b0, 2, 5);
    chk("push_3_nbits", nbits, 4);
    chk("push_3_bits", int'(bits_v[3:0]), 'h3);
    chk("count_after_two_push", int'(count), 2);
    clr_rec();
    do_cmd(POP, 4'h0, 4'h3, 1'b0, 1, 5);
    chk("pop_nbits", nbits, 4);
    chk("pop_dir", ndir1, 4);
    do_cmd(POP, 4'h0, 4'hA, 1'b0, 0, 5);

    // Overflow
    do_cmd(PUSH, 4'h1, 4'h0, 1'b0, 1, 5);
    do_cmd(PUSH, 4'h2, 4'h0, 1'b0, 2, 5);
    do_cmd(PUSH, 4'h3, 4'h0, 1'b0, 3, 5);
    do_cmd(PUSH, 4'h4, 4'h0, 1'b0, 4, 5);
    clr_rec();
    do_cmd(PUSH, 4'h5, 4'h0, 1'b1, 4, 1);
    chk("overflow_no_shift", nbits, 0);
    do_cmd(POP, 4'h0, 4'h4, 1'b0, 3, 5);

    // Reserved op leaves count alone
    clr_rec();
    do_cmd(RSVD, 4'hF, 4'h0, 1'b1, 3, 1);
    chk("rsvd_no_shift", nbits, 0);

    // Clear with 3 words stacked, then underflow
    clr_rec();
    do_cmd(CLEAR, 4'h0, 4'h0, 1'b0, 0, 2);
    chk("clear_sr_rst_cycles", nrst, 1);
    chk("clear_no_shift", nbits, 0);
    clr_rec();
    do_cmd(POP, 4'h0, 4'h0, 1'b1, 0, 1);
    chk("underflow_no_shift", nbits, 0);

    // Reset mid-PUSH: no response may appear
    t = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    cmd_valid = 1'b1; cmd_op = PUSH; cmd_data = 4'h7;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("midburst_sr_en_cycle1", int'(sr_en), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midburst_rst_sr_rst", int'(sr_rst), 1);
    chk("midburst_rst_cmd_ready", int'(cmd_ready), 0);
    chk("midburst_rst_sr_en", int'(sr_en), 0);
    @(negedge clk);
    chk("midburst_count", int'(count), 0);
    rst_n = 1'b1;
    #1;
    chk("midburst_ready_after_release", int'(cmd_ready), 1);
    repeat (8) @(negedge clk);
    do_cmd(PUSH, 4'h6, 4'h0, 1'b0, 1, 5);
    do_cmd(POP, 4'h0, 4'h6, 1'b0, 0, 5);

    // Held cmd_valid: one accepted PUSH every WIDTH+2 cycles
    cmd_valid = 1'b1; cmd_op = PUSH; cmd_data = 4'h5;
    hs_prev = 0;
    for (int k = 0; k < 3; k++) begin
      t = 0;
      nr = 0;
      @(negedge clk);
      while (cmd_ready !== 1'b1 && t < 50) begin
        nr++;
        @(negedge clk);
        t++;
      end
      e.data = 4'h0; e.err = 1'b0; e.cnt = k + 1; e.hs = cyc; e.lat = 5;
      exp_q.push_back(e);
      if (k > 0) begin
        chk("held_valid_interval", cyc - hs_prev, 6);
        chk("held_valid_not_ready_cycles", nr, 5);
      end
      hs_prev = cyc;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_rsp();
    do_cmd(POP, 4'h0, 4'h5, 1'b0, 2, 5);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
